// File: rtl/vrased_rst_ctrl_if.sv
// ---------------------------------------------------------------------------
// vrased_rst_ctrl_if
// Bundle between the violation monitors / core and the PUC reset controller.
//
// Optional cause logging in vrased_rst_ctrl is enabled by the macro
// VRASED_RST_CAUSE_LOG_EN. This interface is the same in both builds.
//
// Signals:
//   viol_stack, viol_atomic, viol_dma : level violation flags from the monitors
//   pc        [15:0]                  : current program counter of the core
//   cause_clr                         : single-cycle clear of cause / viol_cnt
//   puc_rst                           : registered reset request to the core
//   cause     [3:0]                   : sticky {timeout, dma, atomic, stack}
//   viol_cnt  [CNT_W-1:0]             : saturating violation episode count
//   busy                              : controller is not idle
//
// Modports:
//   master : the monitor/core side (drives violations, pc, cause_clr)
//   slave  : the reset controller
// ---------------------------------------------------------------------------
interface vrased_rst_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             viol_stack;
    logic             viol_atomic;
    logic             viol_dma;
    logic [15:0]      pc;
    logic             cause_clr;
    logic             puc_rst;
    logic [3:0]       cause;
    logic [CNT_W-1:0] viol_cnt;
    logic             busy;

    modport master (
        output viol_stack, viol_atomic, viol_dma, pc, cause_clr,
        input  puc_rst, cause, viol_cnt, busy
    );

    modport slave (
        input  viol_stack, viol_atomic, viol_dma, pc, cause_clr,
        output puc_rst, cause, viol_cnt, busy
    );
endinterface

// File: rtl/vrased_rst_ctrl.sv
// ---------------------------------------------------------------------------
// vrased_rst_ctrl
// Merges the stack/key-access, atomicity and DMA violation flags into one
// registered, stretched PUC reset request. After releasing the request it
// waits for the core to reach the reset handler before re-arming; if the core
// never gets there within WAIT_TIMEOUT cycles the request is re-asserted.
//
// Optional feature (macro VRASED_RST_CAUSE_LOG_EN):
//   defined   : sticky cause vector and saturating episode counter are kept,
//               cleared by cause_clr while idle.
//   undefined : cause and viol_cnt read as 0, cause_clr is ignored; the state
//               machine, puc_rst and busy behave identically.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : vrased_rst_ctrl_if.slave (violations, pc, cause_clr in;
//          puc_rst, cause, viol_cnt, busy out)
// ---------------------------------------------------------------------------
module vrased_rst_ctrl #(
    parameter int          HOLD_CYCLES   = 8,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
    parameter int          WAIT_TIMEOUT  = 64,
    parameter int          CNT_W         = 8
) (
    input logic              clk,
    input logic              rst,
    vrased_rst_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        WAIT_RV = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] TMO_LAST  = 8'(WAIT_TIMEOUT - 1);

    state_t     state_reg;
    logic       puc_rst_reg;
    logic       busy_reg;
    logic [7:0] hold_reg;
    logic [7:0] tmo_reg;

    logic [2:0] v;
    logic       any_v;
    logic       at_handler;
    logic       tmo_hit;

    assign v          = {bus.viol_dma, bus.viol_atomic, bus.viol_stack};
    assign any_v      = |v;
    assign at_handler = (bus.pc == RESET_HANDLER);
    assign tmo_hit    = (tmo_reg == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            puc_rst_reg <= 1'b0;
            busy_reg    <= 1'b0;
            hold_reg    <= 8'd0;
            tmo_reg     <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_v) begin
                        state_reg   <= ASSERT;
                        puc_rst_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        hold_reg    <= HOLD_LOAD;
                    end else begin
                        puc_rst_reg <= 1'b0;
                    end
                end
                ASSERT: begin
                    // A violation during the hold restarts the full hold time;
                    // pc is deliberately not looked at here.
                    if (any_v) begin
                        hold_reg <= HOLD_LOAD;
                    end else if (hold_reg == 8'd0) begin
                        state_reg   <= WAIT_RV;
                        puc_rst_reg <= 1'b0;
                        tmo_reg     <= 8'd0;
                    end else begin
                        hold_reg <= hold_reg - 8'd1;
                    end
                end
                WAIT_RV: begin
                    tmo_reg <= tmo_reg + 8'd1;
                    // New violation beats the reset-handler check; timeout
                    // only fires when neither happened this cycle.
                    if (any_v || (!at_handler && tmo_hit)) begin
                        state_reg   <= ASSERT;
                        puc_rst_reg <= 1'b1;
                        hold_reg    <= HOLD_LOAD;
                    end else if (at_handler) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    puc_rst_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.puc_rst = puc_rst_reg;
    assign bus.busy    = busy_reg;

`ifdef VRASED_RST_CAUSE_LOG_EN
    logic [3:0]       cause_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_sat_next;
    logic [2:0]       cause_or_next;
    logic             new_episode;
    logic             timeout_fire;
    logic             clr_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cause
            assign cause_or_next[gi] = cause_reg[gi] | v[gi];
        end
    endgenerate

    // An episode starts on a violation seen from IDLE or WAIT_RV; stretches
    // inside ASSERT belong to the episode already counted.
    assign new_episode  = any_v && ((state_reg == IDLE) || (state_reg == WAIT_RV));
    assign timeout_fire = (state_reg == WAIT_RV) && !any_v && !at_handler && tmo_hit;
    assign clr_ok       = (state_reg == IDLE) && bus.cause_clr;
    assign cnt_sat_next = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cause_reg <= 4'd0;
            cnt_reg   <= '0;
        end else if (clr_ok) begin
            // Clear wins over history but not over a violation arriving now.
            cause_reg <= {1'b0, v};
            cnt_reg   <= any_v ? CNT_W'(1) : '0;
        end else begin
            cause_reg[2:0] <= cause_or_next;
            if (timeout_fire) begin
                cause_reg[3] <= 1'b1;
            end
            if (new_episode) begin
                cnt_reg <= cnt_sat_next;
            end
        end
    end

    assign bus.cause    = cause_reg;
    assign bus.viol_cnt = cnt_reg;
`else
    logic unused_cause_clr;
    assign unused_cause_clr = bus.cause_clr;
    assign bus.cause        = 4'd0;
    assign bus.viol_cnt     = '0;
`endif

endmodule

// File: tb/tb_vrased_rst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vrased_rst_ctrl
// Directed scenarios followed by randomized traffic. Expected outputs come
// from a deadline-based reference model: the request end time is an absolute
// cycle number and the wait window is measured from the release cycle.
// ---------------------------------------------------------------------------
module tb_vrased_rst_ctrl;
    localparam int          HOLD   = 8;
    localparam int          WAITTO = 64;
    localparam int          CW     = 2;
    localparam logic [15:0] RH     = 16'hFFFE;
    localparam logic [15:0] NRM    = 16'h4000;
    localparam int          CMAX   = (1 << CW) - 1;
`ifdef VRASED_RST_CAUSE_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    vrased_rst_ctrl_if #(.CNT_W(CW)) vif ();

    vrased_rst_ctrl #(
        .HOLD_CYCLES  (HOLD),
        .RESET_HANDLER(RH),
        .WAIT_TIMEOUT (WAITTO),
        .CNT_W        (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int       cyc = 0;
    bit       m_busy = 0;
    bit       m_puc = 0;
    int       release_at = 0;
    int       wait_since = 0;
    bit [3:0] m_cause = 0;
    int       m_cnt = 0;

    // run-length measurement of puc_rst
    int hi_run = 0, lo_run = 0, last_hi = 0, last_lo = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int sat_inc(input int c);
        return (c < CMAX) ? c + 1 : CMAX;
    endfunction

    task automatic model_edge(input logic [2:0] v, input logic [15:0] p,
                              input logic clr, input logic r);
        cyc++;
        if (r) begin
            m_busy = 0; m_puc = 0; m_cause = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (clr) begin m_cause = 0; m_cnt = 0; end
            if (v != 0) begin
                m_busy = 1; m_puc = 1; release_at = cyc + HOLD;
                m_cause[2:0] |= v; m_cnt = sat_inc(m_cnt);
            end
        end else if (m_puc) begin
            m_cause[2:0] |= v;
            if (v != 0) release_at = cyc + HOLD;
            else if (cyc == release_at) begin m_puc = 0; wait_since = cyc; end
        end else begin
            m_cause[2:0] |= v;
            if (v != 0) begin
                m_puc = 1; release_at = cyc + HOLD; m_cnt = sat_inc(m_cnt);
            end else if (p == RH) begin
                m_busy = 0;
            end else if (cyc - wait_since == WAITTO) begin
                m_puc = 1; release_at = cyc + HOLD; m_cause[3] = 1'b1;
            end
        end
    endtask

    task automatic step(input logic [2:0] v, input logic [15:0] p,
                        input logic clr, input logic r);
        vif.viol_stack  = v[0];
        vif.viol_atomic = v[1];
        vif.viol_dma    = v[2];
        vif.pc          = p;
        vif.cause_clr   = clr;
        rst             = r;
        @(posedge clk);
        model_edge(v, p, clr, r);
        #1;
        chk("puc_rst",  vif.puc_rst,  m_puc);
        chk("busy",     vif.busy,     m_busy);
        chk("cause",    vif.cause,    LOG_EN ? m_cause : 4'd0);
        chk("viol_cnt", vif.viol_cnt, LOG_EN ? m_cnt : 0);
        if (vif.puc_rst) begin
            hi_run++;
            if (lo_run != 0) begin last_lo = lo_run; lo_run = 0; end
        end else begin
            lo_run++;
            if (hi_run != 0) begin last_hi = hi_run; hi_run = 0; end
        end
    endtask

    task automatic wait_low();
        for (int i = 0; i < 300 && vif.puc_rst; i++) step(3'b000, NRM, 0, 0);
        if (vif.puc_rst) chk("wait_low_bound", vif.puc_rst, 0);
    endtask

    task automatic wait_high();
        for (int i = 0; i < 300 && !vif.puc_rst; i++) step(3'b000, NRM, 0, 0);
        if (!vif.puc_rst) chk("wait_high_bound", vif.puc_rst, 1);
    endtask

    initial begin
        step(3'b000, NRM, 0, 1);
        step(3'b000, NRM, 0, 1);
        step(3'b000, NRM, 0, 0);

        // single pulse, release, handler reached 3 cycles later
        hi_run = 0; lo_run = 0;
        step(3'b001, NRM, 0, 0);
        wait_low();
        chk("pulse_len", last_hi, HOLD);
        step(3'b000, NRM, 0, 0);
        step(3'b000, NRM, 0, 0);
        step(3'b000, RH, 0, 0);
        chk("pulse_idle_busy", vif.busy, 0);

        // stretch: atomic, then dma 5 cycles later
        step(3'b000, NRM, 1, 0);
        hi_run = 0; lo_run = 0;
        step(3'b010, NRM, 0, 0);
        for (int i = 0; i < 4; i++) step(3'b000, NRM, 0, 0);
        step(3'b100, NRM, 0, 0);
        wait_low();
        chk("stretch_len", last_hi, HOLD + 5);
        step(3'b000, RH, 0, 0);

        // timeout re-assert
        step(3'b000, NRM, 1, 0);
        hi_run = 0; lo_run = 0;
        step(3'b001, NRM, 0, 0);
        wait_low();
        wait_high();
        chk("timeout_gap", last_lo, WAITTO);
        wait_low();
        chk("timeout_hold", last_hi, HOLD);
        step(3'b000, RH, 0, 0);

        // re-violation in WAIT_RV with handler pc in the same cycle
        step(3'b001, NRM, 0, 0);
        wait_low();
        step(3'b000, NRM, 0, 0);
        step(3'b100, RH, 0, 0);
        chk("reviol_puc", vif.puc_rst, 1);
        wait_low();
        step(3'b000, RH, 0, 0);

        // saturation over 5 episodes
        for (int e = 0; e < 5; e++) begin
            step(3'b001, NRM, 0, 0);
            wait_low();
            step(3'b000, RH, 0, 0);
        end
        chk("sat_cnt", vif.viol_cnt, LOG_EN ? CMAX : 0);

        // cause_clr ignored in ASSERT, honoured in IDLE, merged with a violation
        step(3'b001, NRM, 0, 0);
        step(3'b000, NRM, 1, 0);
        wait_low();
        step(3'b000, RH, 0, 0);
        step(3'b000, NRM, 1, 0);
        step(3'b001, NRM, 1, 0);
        wait_low();
        step(3'b000, RH, 0, 0);

        // reset in the middle of an episode
        step(3'b010, NRM, 0, 0);
        step(3'b000, NRM, 0, 0);
        step(3'b000, NRM, 0, 0);
        step(3'b000, NRM, 0, 1);
        chk("midrst_puc", vif.puc_rst, 0);
        step(3'b000, NRM, 0, 0);

        // randomized traffic, alternating busy and quiet phases
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  rv;
            logic [15:0] rp;
            logic        rc, rr;
            bit          quiet;
            quiet = ((i / 250) % 2) == 1;
            for (int b = 0; b < 3; b++)
                rv[b] = quiet ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0);
            rp = (quiet ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 7) == 0))
                 ? RH : 16'($urandom_range(0, 16'hFFFD));
            rc = ($urandom_range(0, 9) == 0);
            rr = ($urandom_range(0, 399) == 0);
            step(rv, rp, rc, rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
